lamp_sequence_monitor: RTL

//   Receive-side checker for the cyclic lamp bus. Samples the one-hot 3-bit light

---
 rtl/lamp_sequence_monitor_if.sv | 25 ++
 rtl/lamp_sequence_monitor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lamp_sequence_monitor_if.sv
// Lamp bus seen by the sequence monitor: the sampled light code and clear request in,
// the decoded phase, lock/cycle status and error flags out.
interface lamp_sequence_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic [0:2]       light;
  logic             err_clear;
  logic [1:0]       phase;
  logic             locked;
  logic [CNT_W-1:0] cycle_count;
  logic             err_illegal;
  logic             err_order;
  logic             err_dwell;
  logic             fault_sticky;

  modport master (
    output light, err_clear,
    input  phase, locked, cycle_count, err_illegal, err_order, err_dwell, fault_sticky
  );

  modport slave (
    input  light, err_clear,
    output phase, locked, cycle_count, err_illegal, err_order, err_dwell, fault_sticky
  );
endinterface

// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the cyclic lamp bus: decodes the one-hot light code, checks
// RED->GREEN->YELLOW ordering and per-phase dwell, and counts completed cycles.
module lamp_sequence_monitor #(
  parameter int MAX_DWELL = 1,
  parameter int DWELL_W   = 8,
  parameter int CNT_W     = 8
) (
  input logic                     clock,
  input logic                     reset,
  lamp_sequence_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    UNSYNC = 2'b00,
    TRACK  = 2'b01
  } state_t;

  localparam logic [DWELL_W-1:0] MAX_D = DWELL_W'(MAX_DWELL);

  function automatic logic is_one_hot(input logic [0:2] code);
    return (code == 3'b100) || (code == 3'b010) || (code == 3'b001);
  endfunction

  // Successor is a rotation: R(100)->G(010)->Y(001)->R(100).
  function automatic logic [0:2] succ_code(input logic [0:2] code);
    return {code[2], code[0], code[1]};
  endfunction

  function automatic logic [1:0] decode_phase(input logic [0:2] code);
    logic [1:0] ph;
    case (code)
      3'b100:  ph = 2'd0;
      3'b010:  ph = 2'd1;
      3'b001:  ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  state_t             state_r, state_s;
  logic [0:2]         last_code_r, last_code_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [1:0]         phase_r, phase_s;
  logic               locked_r, locked_s;
  logic [CNT_W-1:0]   cycle_count_r, cycle_count_s;
  logic               err_illegal_r, err_illegal_s;
  logic               err_order_r, err_order_s;
  logic               err_dwell_r, err_dwell_s;
  logic               fault_sticky_r, fault_sticky_s;

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= UNSYNC;
      last_code_r    <= 3'b000;
      dwell_r        <= '0;
      phase_r        <= 2'd3;
      locked_r       <= 1'b0;
      cycle_count_r  <= '0;
      err_illegal_r  <= 1'b0;
      err_order_r    <= 1'b0;
      err_dwell_r    <= 1'b0;
      fault_sticky_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      last_code_r    <= last_code_s;
      dwell_r        <= dwell_s;
      phase_r        <= phase_s;
      locked_r       <= locked_s;
      cycle_count_r  <= cycle_count_s;
      err_illegal_r  <= err_illegal_s;
      err_order_r    <= err_order_s;
      err_dwell_r    <= err_dwell_s;
      fault_sticky_r <= fault_sticky_s;
    end
  end

  // Next-state, sequence checks and error flags for the current sample.
  always_comb begin
    state_s       = state_r;
    last_code_s   = last_code_r;
    dwell_s       = dwell_r;
    phase_s       = phase_r;
    locked_s      = locked_r;
    cycle_count_s = cycle_count_r;
    err_illegal_s = 1'b0;
    err_order_s   = 1'b0;
    err_dwell_s   = 1'b0;

    if (!is_one_hot(bus.light)) begin
      err_illegal_s = 1'b1;
      phase_s       = 2'd3;
      locked_s      = 1'b0;
      last_code_s   = 3'b000;
      dwell_s       = '0;
      state_s       = UNSYNC;
    end else begin
      case (state_r)
        UNSYNC: begin
          last_code_s = bus.light;
          phase_s     = decode_phase(bus.light);
          dwell_s     = DWELL_W'(1);
          locked_s    = 1'b0;
          state_s     = TRACK;
        end
        TRACK: begin
          if (bus.light == last_code_r) begin
            if (dwell_r < MAX_D) begin
              dwell_s = dwell_r + DWELL_W'(1);
            end else if (dwell_r == MAX_D) begin
              err_dwell_s = 1'b1;
              dwell_s     = MAX_D + DWELL_W'(1);
            end else begin
              dwell_s = dwell_r;
            end
          end else if (bus.light == succ_code(last_code_r)) begin
            last_code_s = bus.light;
            phase_s     = decode_phase(bus.light);
            dwell_s     = DWELL_W'(1);
            locked_s    = 1'b1;
            if ((last_code_r == 3'b001) && (bus.light == 3'b100)) begin
              cycle_count_s = cycle_count_r + CNT_W'(1);
            end else begin
              cycle_count_s = cycle_count_r;
            end
          end else begin
            // Out-of-order code becomes the new reference for the next check.
            err_order_s = 1'b1;
            locked_s    = 1'b0;
            last_code_s = bus.light;
            phase_s     = decode_phase(bus.light);
            dwell_s     = DWELL_W'(1);
          end
        end
        default: begin
          state_s     = UNSYNC;
          last_code_s = 3'b000;
          dwell_s     = '0;
          phase_s     = 2'd3;
          locked_s    = 1'b0;
        end
      endcase
    end

    if (err_illegal_s || err_order_s || err_dwell_s) begin
      fault_sticky_s = 1'b1;
    end else if (bus.err_clear) begin
      fault_sticky_s = 1'b0;
    end else begin
      fault_sticky_s = fault_sticky_r;
    end
  end

  assign bus.phase        = phase_r;
  assign bus.locked       = locked_r;
  assign bus.cycle_count  = cycle_count_r;
  assign bus.err_illegal  = err_illegal_r;
  assign bus.err_order    = err_order_r;
  assign bus.err_dwell    = err_dwell_r;
  assign bus.fault_sticky = fault_sticky_r;

endmodule
